// File: rtl/fetch_unit_pkg.sv
// Shared instruction-side definitions for the fetch stage and the assembler
// programs: run-state encoding, default program counter width and the
// subroutine entry-point layout.
package fetch_unit_pkg;

    localparam int PC_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } run_state_e;

    // Entry address of subroutine idx; callers truncate to their pc width.
    function automatic logic [31:0] sub_entry(input logic [3:0]  idx,
                                              input logic [31:0] base,
                                              input logic [31:0] stride);
        sub_entry = base + ({28'd0, idx} * stride);
    endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// LIFO return-address stack. The top entry is visible combinationally so a
// return can load it into the pc in the same cycle it is popped. A push
// while full and a pop while empty are ignored; the caller flags them.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = PTR_W'(DEPTH) == '0 ? {1'b1, {PTR_W{1'b0}}}
                                                            : {1'b0, PTR_W'(DEPTH)};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   count_r;
    logic [PTR_W-1:0] top_idx_s;

    // Index of the most recently pushed entry (wraps harmlessly when empty).
    always_comb begin
        top_idx_s = count_r[PTR_W-1:0] - {{(PTR_W-1){1'b0}}, 1'b1};
    end

    assign top   = mem_r[top_idx_s];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {(PTR_W+1){1'b0}});

    // Occupancy count and storage; clear empties the stack on a (re)start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clear) begin
            count_r <= {(PTR_W+1){1'b0}};
        end else if (push && !full) begin
            mem_r[count_r[PTR_W-1:0]] <= din;
            count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter / control-flow stage. Sequences pc from decoder requests
// (increment, branch, call, return, halt) under an IDLE/RUN/HALT machine.
// Optional feature: define FETCH_COUNT_EN to build the retired-fetch
// counter; otherwise fetch_count is tied to zero.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = 4,
    parameter int SUB_BASE    = 100,
    parameter int SUB_STRIDE  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stall,
    input  logic            br_req,
    input  logic [PC_W-1:0] br_target,
    input  logic            jsr_req,
    input  logic [3:0]      jsr_idx,
    input  logic            ret_req,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            done,
    output logic            stack_err,
    output logic [15:0]     fetch_count
);

    run_state_e      state_r;
    logic [PC_W-1:0] pc_r;
    logic            running_r;
    logic            done_r;
    logic            stack_err_r;

    logic            run_go_s;
    logic            clear_s;
    logic            push_s;
    logic            pop_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] jsr_target_s;
    logic [PC_W-1:0] top_s;
    logic            full_s;
    logic            empty_s;

    // Stack control: only the winning request of a non-stalled RUN cycle acts.
    always_comb begin
        run_go_s     = (state_r == ST_RUN) && !stall;
        clear_s      = start && (state_r != ST_RUN);
        pc_inc_s     = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        jsr_target_s = PC_W'(sub_entry(jsr_idx, 32'(SUB_BASE), 32'(SUB_STRIDE)));
        push_s       = 1'b0;
        pop_s        = 1'b0;
        if (run_go_s && !halt_req) begin
            if (ret_req) begin
                pop_s = !empty_s;
            end else if (jsr_req) begin
                push_s = !full_s;
            end else begin
                pop_s  = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_s),
        .push    (push_s),
        .pop     (pop_s),
        .din     (pc_inc_s),
        .top     (top_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Run-state machine, pc register and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= {PC_W{1'b0}};
            running_r   <= 1'b0;
            done_r      <= 1'b0;
            stack_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pc_r <= {PC_W{1'b0}};
                    if (start) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        done_r    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (halt_req) begin
                            state_r   <= ST_HALT;
                            running_r <= 1'b0;
                            done_r    <= 1'b1;
                        end else if (ret_req) begin
                            if (empty_s) begin
                                stack_err_r <= 1'b1;
                                state_r     <= ST_HALT;
                                running_r   <= 1'b0;
                                done_r      <= 1'b1;
                            end else begin
                                pc_r <= top_s;
                            end
                        end else if (jsr_req) begin
                            if (full_s) begin
                                stack_err_r <= 1'b1;
                                state_r     <= ST_HALT;
                                running_r   <= 1'b0;
                                done_r      <= 1'b1;
                            end else begin
                                pc_r <= jsr_target_s;
                            end
                        end else if (br_req) begin
                            pc_r <= br_target;
                        end else begin
                            pc_r <= pc_inc_s;
                        end
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state_r     <= ST_RUN;
                        pc_r        <= {PC_W{1'b0}};
                        running_r   <= 1'b1;
                        done_r      <= 1'b0;
                        stack_err_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    pc_r        <= {PC_W{1'b0}};
                    running_r   <= 1'b0;
                    done_r      <= 1'b0;
                    stack_err_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count_r;

    // Saturating count of non-stalled RUN cycles, restarted by start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_r <= 16'd0;
        end else if (clear_s) begin
            fetch_count_r <= 16'd0;
        end else if (run_go_s && (fetch_count_r != 16'hFFFF)) begin
            fetch_count_r <= fetch_count_r + 16'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign fetch_count = fetch_count_r;
`else
    assign fetch_count = 16'd0;
`endif

    assign pc        = pc_r;
    assign running   = running_r;
    assign done      = done_r;
    assign stack_err = stack_err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stall, br_req, jsr_req, ret_req, halt_req;
    logic [9:0]  br_target;
    logic [3:0]  jsr_idx;
    logic [9:0]  pc;
    logic        running, done, stack_err;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: 0 idle, 1 run, 2 halt
    int m_state;
    int m_pc;
    int m_fc;
    bit m_err;
    int m_stack[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stall       (stall),
        .br_req      (br_req),
        .br_target   (br_target),
        .jsr_req     (jsr_req),
        .jsr_idx     (jsr_idx),
        .ret_req     (ret_req),
        .halt_req    (halt_req),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .stack_err   (stack_err),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic       start, stall, br;
        logic [9:0] bt;
        logic       jsr;
        logic [3:0] idx;
        logic       ret, halt;
        int         pc;
        logic       run, dn, err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic sl, input logic b, input int bt,
                                input logic j, input int idx, input logic r, input logic h,
                                input int epc, input logic er, input logic ed, input logic ee);
        vec_t v;
        v.start = s; v.stall = sl; v.br = b; v.bt = 10'(bt);
        v.jsr = j; v.idx = 4'(idx); v.ret = r; v.halt = h;
        v.pc = epc; v.run = er; v.dn = ed; v.err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic sl, input logic b, input logic [9:0] bt,
                         input logic j, input logic [3:0] idx, input logic r, input logic h);
        start = s; stall = sl; br_req = b; br_target = bt;
        jsr_req = j; jsr_idx = idx; ret_req = r; halt_req = h;
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_fc = 0; m_err = 1'b0;
        m_stack.delete();
    endtask

    // Apply the rules of one clock edge to the model using current inputs.
    task automatic model_step();
        if (m_state == 0) begin
            if (start) begin m_state = 1; m_pc = 0; m_fc = 0; m_stack.delete(); end
        end else if (m_state == 1) begin
            if (!stall) begin
                if (m_fc < 65535) m_fc = m_fc + 1;
                if (halt_req) m_state = 2;
                else if (ret_req) begin
                    if (m_stack.size() == 0) begin m_err = 1'b1; m_state = 2; end
                    else m_pc = m_stack.pop_back();
                end else if (jsr_req) begin
                    if (m_stack.size() == 4) begin m_err = 1'b1; m_state = 2; end
                    else begin
                        m_stack.push_back((m_pc + 1) % 1024);
                        m_pc = (100 + int'(jsr_idx) * 16) % 1024;
                    end
                end else if (br_req) m_pc = int'(br_target);
                else m_pc = (m_pc + 1) % 1024;
            end
        end else begin
            if (start) begin
                m_state = 1; m_pc = 0; m_err = 1'b0; m_fc = 0; m_stack.delete();
            end
        end
    endtask

    task automatic check_model(input string tag);
        int fc_exp;
`ifdef FETCH_COUNT_EN
        fc_exp = m_fc;
`else
        fc_exp = 0;
`endif
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".running"}, 32'(running), 32'(m_state == 1));
        chk({tag, ".done"}, 32'(done), 32'(m_state == 2));
        chk({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
        chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(fc_exp));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        reset_n = 1'b1;

        //        st  sl  br  bt    jsr idx ret halt  pc   run dn err
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,   0,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,   1,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,   2,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,   3,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,   4,   1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 87,  0, 0, 0, 0,   87,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0, 0,   100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 112, 0, 0, 0, 0,   112, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 1, 0,   88,  1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 9,   1, 1, 0, 0,   116, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0, 1,   116, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 0, 1, 0,   116, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0, 0,   116, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 1, 0,   89,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 1, 0,   89,  0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,   0,   1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,   1,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1,   1,   0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,   0,   1, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].start, tbl[i].stall, tbl[i].br, tbl[i].bt,
                  tbl[i].jsr, tbl[i].idx, tbl[i].ret, tbl[i].halt);
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.pc_exp", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("vec%0d.run_exp", i), 32'(running), 32'(tbl[i].run));
            chk($sformatf("vec%0d.done_exp", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("vec%0d.err_exp", i), 32'(stack_err), 32'(tbl[i].err));
`ifdef FETCH_COUNT_EN
            if (i == 5) chk("fetch_count_after_5", 32'(fetch_count), 32'd5);
`endif
        end

        // Nested calls: four fit, the fifth overflows and halts in place.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'(k), 1'b0, 1'b0);
            cycle($sformatf("nest%0d", k));
            chk($sformatf("nest%0d.pc_exp", k), 32'(pc), 32'(100 + 16 * k));
        end
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 4'd4, 1'b0, 1'b0);
        cycle("overflow");
        chk("overflow.pc_exp", 32'(pc), 32'd148);
        chk("overflow.err_exp", 32'(stack_err), 32'd1);
        chk("overflow.done_exp", 32'(done), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle("restart");
        chk("restart.err_exp", 32'(stack_err), 32'd0);
        chk("restart.pc_exp", 32'(pc), 32'd0);

        // Wrap at the top of the address space.
        drive(1'b0, 1'b0, 1'b1, 10'd1023, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle("to1023");
        cycle("wrap");
        chk("wrap.pc_exp", 32'(pc), 32'd0);

        // Asynchronous reset between clock edges.
        drive(1'b0, 1'b0, 1'b1, 10'd50, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle("to50");
        chk("to50.pc_exp", 32'(pc), 32'd50);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.pc", 32'(pc), 32'd0);
        chk("async_rst.running", 32'(running), 32'd0);
        check_model("async_rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Return as the very first RUN action underflows.
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle("start2");
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle("underflow");
        chk("underflow.err_exp", 32'(stack_err), 32'd1);
        chk("underflow.done_exp", 32'(done), 32'd1);
        chk("underflow.pc_exp", 32'(pc), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(31) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(5) == 0), 10'($urandom_range(1023)),
                  ($urandom_range(7) == 0), 4'($urandom_range(15)),
                  ($urandom_range(7) == 0), ($urandom_range(63) == 0));
            if (m_state != 1 && $urandom_range(3) == 0) start = 1'b1;
            cycle($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
